// File: rtl/superscalar_fetch_buffer.sv
`timescale 1ns/1ps
// superscalar_fetch_buffer
// N-wide fetch front end. It drives the fetch PC, captures up to FETCH_WIDTH
// consecutive instruction words per cycle and cuts the group short after a
// predicted-taken branch. Instructions and their PCs are held in program order
// in a circular queue, and up to ISSUE_WIDTH of the oldest are presented to
// decode. A flush empties the queue and redirects fetch.
module superscalar_fetch_buffer #(
  parameter int          FETCH_WIDTH = 2,
  parameter int          ISSUE_WIDTH = 2,
  parameter int          DEPTH       = 8,
  parameter logic [31:0] RESET_PC    = 32'h0,
  localparam int         PSW         = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
  localparam int         AIW         = $clog2(ISSUE_WIDTH + 1),
  localparam int         CW          = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [31:0]               fetch_pc,
  input  logic [32*FETCH_WIDTH-1:0] imem_instr,
  input  logic                      pred_taken,
  input  logic [PSW-1:0]            pred_slot,
  input  logic [31:0]               pred_target,
  input  logic                      flush,
  input  logic [31:0]               flush_target,
  input  logic [AIW-1:0]            issue_accept,
  output logic [ISSUE_WIDTH-1:0]    issue_valid,
  output logic [32*ISSUE_WIDTH-1:0] issue_instr,
  output logic [32*ISSUE_WIDTH-1:0] issue_pc,
  output logic [CW-1:0]             count,
  output logic                      stall_fetch
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(FETCH_WIDTH + 1);
  // Highest occupancy that still leaves room for a full fetch group.
  localparam logic [CW-1:0] ENQ_MAX_COUNT = CW'(DEPTH - FETCH_WIDTH);

  // Entry storage; deliberately not reset, validity comes from count alone.
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic [AW-1:0] head_reg;
  logic [AW-1:0] tail_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   pc_reg;

  logic [NW-1:0] grp_len;
  logic [31:0]   grp_bytes;
  logic          enq;
  logic [CW-1:0] deq_num;
  logic          flush_lsb_unused;

  logic [AW-1:0] wr_addr [FETCH_WIDTH];
  logic [31:0]   wr_pc   [FETCH_WIDTH];
  logic          wr_en   [FETCH_WIDTH];

  // The two low redirect bits are dropped; word alignment is forced.
  assign flush_lsb_unused = ^flush_target[1:0];

  // Group length: stop after the predicted-taken slot; an out-of-range slot means a full group.
  always_comb begin
    grp_len = NW'(FETCH_WIDTH);
    if (pred_taken && (32'(pred_slot) < 32'(FETCH_WIDTH))) begin
      grp_len = NW'(pred_slot) + NW'(1);
    end
  end

  assign grp_bytes = 32'(grp_len) << 2;

  // Room is judged on the pre-edge occupancy; a same-cycle dequeue is not credited.
  assign enq         = !flush && (count_reg <= ENQ_MAX_COUNT);
  assign stall_fetch = (count_reg > ENQ_MAX_COUNT);

  // Dequeue amount: the smallest of request, occupancy and issue width; none during flush.
  always_comb begin
    deq_num = count_reg;
    if (32'(issue_accept) < 32'(deq_num)) begin
      deq_num = CW'(issue_accept);
    end
    if (32'(ISSUE_WIDTH) < 32'(deq_num)) begin
      deq_num = CW'(ISSUE_WIDTH);
    end
    if (flush) begin
      deq_num = '0;
    end
  end

  // Per-slot write address, PC and enable; a group may straddle the wrap point.
  generate
    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_wr
      assign wr_addr[gi] = tail_reg + AW'(gi);
      assign wr_pc[gi]   = pc_reg + 32'(4 * gi);
      assign wr_en[gi]   = enq && (32'(gi) < 32'(grp_len));
    end
  endgenerate

  // Entry storage write for the accepted slots of the current group.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (wr_en[i]) begin
        instr_mem[wr_addr[i]] <= imem_instr[32*i +: 32];
        pc_mem[wr_addr[i]]    <= wr_pc[i];
      end
    end
  end

  // Pointer, occupancy and fetch PC update; reset beats flush, flush beats fetch/issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg    <= RESET_PC;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      pc_reg    <= {flush_target[31:2], 2'b00};
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_reg + AW'(deq_num);
      count_reg <= count_reg + (enq ? CW'(grp_len) : CW'(0)) - deq_num;
      if (enq) begin
        tail_reg <= tail_reg + AW'(grp_len);
        pc_reg   <= pred_taken ? pred_target : (pc_reg + grp_bytes);
      end
    end
  end

  assign fetch_pc = pc_reg;
  assign count    = count_reg;

  // Issue window: slot i shows entry head+i; validity is purely occupancy based.
  generate
    for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_issue
      logic [AW-1:0] rd_addr;
      assign rd_addr                 = head_reg + AW'(gi);
      assign issue_valid[gi]         = (32'(count_reg) > gi);
      assign issue_instr[32*gi +: 32] = instr_mem[rd_addr];
      assign issue_pc[32*gi +: 32]    = pc_mem[rd_addr];
    end
  endgenerate

endmodule

// File: tb/tb_superscalar_fetch_buffer.sv
`timescale 1ns/1ps
// Bench for superscalar_fetch_buffer: directed scenarios followed by random
// traffic. Expected entries live in a program-order queue; the driver pushes
// what each cycle should enqueue and a separate monitor compares the issue
// port against the queue front and retires what decode consumes.
module tb_superscalar_fetch_buffer;

  localparam int          FW       = 2;
  localparam int          IW       = 2;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   fetch_pc;
  logic [32*FW-1:0] imem_instr;
  logic          pred_taken;
  logic [0:0]    pred_slot;
  logic [31:0]   pred_target;
  logic          flush;
  logic [31:0]   flush_target;
  logic [1:0]    issue_accept;
  logic [IW-1:0] issue_valid;
  logic [32*IW-1:0] issue_instr;
  logic [32*IW-1:0] issue_pc;
  logic [3:0]    count;
  logic          stall_fetch;

  superscalar_fetch_buffer #(
    .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .imem_instr(imem_instr),
    .pred_taken(pred_taken), .pred_slot(pred_slot), .pred_target(pred_target),
    .flush(flush), .flush_target(flush_target), .issue_accept(issue_accept),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_pc(issue_pc),
    .count(count), .stall_fetch(stall_fetch)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  generate
    for (genvar gi = 0; gi < FW; gi++) begin : g_imem
      assign imem_instr[32*gi +: 32] = instr_of(fetch_pc + 32'(4 * gi));
    end
  endgenerate

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] model_pc;
  bit          mon_en = 1'b0;
  int          total  = 0;
  int          bad    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One fetch/issue cycle: drive inputs after the falling edge, then record
  // the reference effect of the coming rising edge.
  task automatic do_cycle(input int acc, input int pt, input int ps, input logic [31:0] ptgt,
                          input int fl, input logic [31:0] ftgt, input int rst);
    int pre_size;
    int n;
    @(negedge clk);
    reset        = (rst != 0);
    flush        = (fl != 0);
    flush_target = ftgt;
    pred_taken   = (pt != 0);
    pred_slot    = 1'(ps);
    pred_target  = ptgt;
    issue_accept = 2'(acc);
    pre_size     = exp_q.size();
    #2;
    if (rst != 0) begin
      exp_q.delete();
      model_pc = RESET_PC;
    end else if (fl != 0) begin
      exp_q.delete();
      model_pc = ftgt & 32'hFFFF_FFFC;
    end else if (DEPTH - pre_size >= FW) begin
      n = FW;
      if (pt != 0 && ps < FW) n = ps + 1;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back('{pc: model_pc + 32'(4 * i), instr: instr_of(model_pc + 32'(4 * i))});
      end
      model_pc = (pt != 0) ? ptgt : model_pc + 32'(4 * n);
    end
  endtask

  // Monitor: compare the visible state with the reference, then retire what decode takes.
  initial begin
    int sz;
    int d;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        sz = exp_q.size();
        chk("count", 32'(count), 32'(sz));
        chk("stall_fetch", 32'(stall_fetch), (DEPTH - sz < FW) ? 32'd1 : 32'd0);
        chk("fetch_pc", fetch_pc, model_pc);
        for (int i = 0; i < IW; i++) begin
          chk("issue_valid", 32'(issue_valid[i]), (i < sz) ? 32'd1 : 32'd0);
          if (i < sz) begin
            chk("issue_pc", issue_pc[32*i +: 32], exp_q[i].pc);
            chk("issue_instr", issue_instr[32*i +: 32], exp_q[i].instr);
          end
        end
        if (!reset && !flush) begin
          d = int'(issue_accept);
          if (d > sz) d = sz;
          if (d > IW) d = IW;
          if (d > 0) $display("issue n=%0d pc0=%h", d, exp_q[0].pc);
          repeat (d) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    logic [31:0] tgt;
    int          acc;
    int          pt;
    int          ps;
    int          fl;
    int          rs;
    reset        = 1'b1;
    flush        = 1'b0;
    flush_target = '0;
    pred_taken   = 1'b0;
    pred_slot    = '0;
    pred_target  = '0;
    issue_accept = '0;
    model_pc     = RESET_PC;

    do_cycle(0, 0, 0, 0, 0, 0, 1);
    mon_en = 1'b1;

    // Fill with no consumption: groups at 0,8,16,24, then a stalled cycle.
    repeat (5) do_cycle(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_stall", 32'(stall_fetch), 32'd1);
    chk("fill_pc", fetch_pc, 32'd32);

    // Drain two per cycle while refill wraps the pointers.
    repeat (12) do_cycle(2, 0, 0, 0, 0, 0, 0);

    // Predicted-taken branch in slot 0 truncates the group.
    do_cycle(0, 0, 0, 0, 1, 32'h10, 0);
    do_cycle(0, 1, 0, 32'h40, 0, 0, 0);
    @(posedge clk); #1;
    chk("pred_count", 32'(count), 32'd1);
    chk("pred_pc", fetch_pc, 32'h40);
    chk("pred_entry", issue_pc[31:0], 32'h10);
    chk("pred_valid", 32'(issue_valid), 32'd1);
    do_cycle(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("target_entry", issue_pc[63:32], 32'h40);
    do_cycle(0, 0, 0, 0, 0, 0, 0);

    // Flush with five entries, accept and open fetch in the same cycle.
    do_cycle(2, 0, 0, 0, 1, 32'h103, 0);
    @(posedge clk); #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(issue_valid), 32'd0);
    chk("flush_pc", fetch_pc, 32'h100);

    // Accept clipped to occupancy of one.
    do_cycle(0, 1, 0, 32'h200, 0, 0, 0);
    do_cycle(2, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("clip_count", 32'(count), 32'd2);
    chk("clip_head", issue_pc[31:0], 32'h200);

    // Reset pulsed mid-stream with five entries held.
    do_cycle(0, 1, 0, 32'h300, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_pc", fetch_pc, RESET_PC);
    chk("reset_valid", 32'(issue_valid), 32'd0);

    // Random traffic.
    repeat (600) begin
      acc = int'($urandom_range(0, 3));
      pt  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ps  = int'($urandom_range(0, 1));
      tgt = $urandom() & 32'hFFFF_FFFC;
      fl  = ($urandom_range(0, 24) == 0) ? 1 : 0;
      rs  = ($urandom_range(0, 99) == 0) ? 1 : 0;
      do_cycle(acc, pt, ps, tgt, fl, $urandom(), rs);
    end

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
